// File: rtl/cache_fill_fsm_pkg.sv
// cache_fill_fsm_pkg: fill state encoding and block geometry shared by the I-cache and D-cache controllers
package cache_fill_fsm_pkg;
  localparam int DEF_BLOCK_WORDS = 8;
  localparam int DEF_ADDR_W = 16;
  typedef enum logic {IDLE, FILL} fill_state_e;
  function automatic int cnt_w(input int words);
    return $clog2(words) + 1;
  endfunction
endpackage

// File: rtl/fill_counter.sv
// fill_counter: enable/clear up-counter with asynchronous active-low reset
module fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches one cache block from main memory after a miss and streams it into the data/tag arrays
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] data_word_addr,
  output logic              write_tag_array
);
  localparam int CW = cnt_w(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);
  localparam logic [CW-1:0] FULL = CW'(BLOCK_WORDS);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << CW) - 1);
  fill_state_e state;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0] req_cnt, rsp_cnt, req_idx;
  logic accept, req_go, rsp_go, last_rsp, unused_data;
  assign accept = (state == IDLE) && miss_detected;
  assign req_go = (state == FILL) && (req_cnt < FULL);
  assign rsp_go = (state == FILL) && memory_data_valid;
  assign last_rsp = rsp_go && (rsp_cnt == LAST);
  // memory data goes straight to the data array; the FSM only sequences it
  assign unused_data = ^memory_data;
  fill_counter #(.W(CW)) u_req_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (req_go),
    .cnt   (req_cnt)
  );
  fill_counter #(.W(CW)) u_rsp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (rsp_go),
    .cnt   (rsp_cnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
    end else if (accept) begin
      state <= FILL;
      base  <= miss_address & BLK_MASK;
    end else if (last_rsp) begin
      state <= IDLE;
    end
  // clamping at the last word keeps the final request address on the bus once issue is done
  assign req_idx = (req_cnt > LAST) ? LAST : req_cnt;
  assign fsm_busy = rst_n && ((state == FILL) || accept);
  assign mem_en = req_go;
  assign memory_address = base + ADDR_W'({req_idx, 1'b0});
  assign write_data_array = rsp_go;
  assign data_word_addr = base + ADDR_W'({rsp_cnt, 1'b0});
  assign write_tag_array = last_rsp;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed scenarios checked every cycle against a transaction-level fill model
module tb_cache_fill_fsm;
  localparam int BW = 8;
  localparam int AW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic miss_detected = 1'b0;
  logic memory_data_valid = 1'b0;
  logic [AW-1:0] miss_address = '0;
  logic [15:0] memory_data = '0;
  logic fsm_busy, mem_en, write_data_array, write_tag_array;
  logic [AW-1:0] memory_address, data_word_addr;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_tag = 0;
  int n_busy = 0;
  logic [15:0] iss_a[$];
  logic [15:0] wr_a[$];
  int iss_c[$];
  logic m_active = 1'b0;
  logic [15:0] m_base = '0;
  logic [15:0] m_hold = '0;
  int m_issued = 0;
  int m_written = 0;
  logic e_en, e_wr;
  int i0, w0, t0, b0, c0;

  cache_fill_fsm #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_word_addr    (data_word_addr),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: a fill is a block of BW word reads, one issued per cycle, retired one per valid
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_active <= 1'b0;
      m_base <= '0;
      m_hold <= '0;
      m_issued <= 0;
      m_written <= 0;
    end else if (m_active) begin
      if (m_issued < BW) begin
        m_issued <= m_issued + 1;
        m_hold <= m_base + 16'(2 * m_issued);
      end
      if (memory_data_valid) begin
        m_written <= m_written + 1;
        if (m_written == BW - 1) m_active <= 1'b0;
      end
    end else if (miss_detected) begin
      m_active <= 1'b1;
      m_base <= miss_address & ~16'(2 * BW - 1);
      m_issued <= 0;
      m_written <= 0;
    end

  assign e_en = m_active && (m_issued < BW);
  assign e_wr = m_active && memory_data_valid;

  always @(negedge clk) begin
    #2;
    chk("fsm_busy", 32'(fsm_busy), 32'(rst_n && (m_active || miss_detected)));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("memory_address", 32'(memory_address), 32'(e_en ? m_base + 16'(2 * m_issued) : m_hold));
    chk("write_data_array", 32'(write_data_array), 32'(e_wr));
    chk("write_tag_array", 32'(write_tag_array), 32'(e_wr && (m_written == BW - 1)));
    if (e_wr || !rst_n)
      chk("data_word_addr", 32'(data_word_addr), 32'(rst_n ? m_base + 16'(2 * m_written) : 16'h0));
    if (fsm_busy) n_busy <= n_busy + 1;
    if (write_tag_array) n_tag <= n_tag + 1;
    if (mem_en) begin
      iss_a.push_back(memory_address);
      iss_c.push_back(cyc);
    end
    if (write_data_array) wr_a.push_back(data_word_addr);
  end

  task automatic tick(input logic r, input logic m, input logic [15:0] a, input logic v);
    @(negedge clk);
    rst_n = r;
    miss_detected = m;
    miss_address = a;
    memory_data_valid = v;
    memory_data = 16'(cyc);
    #3;
  endtask

  task automatic mark();
    i0 = iss_a.size();
    w0 = wr_a.size();
    t0 = n_tag;
    b0 = n_busy;
  endtask

  // fixed-latency fill: request k issued on cycle k+1, answered lat cycles later
  task automatic fill(input logic [15:0] a, input int lat);
    for (int k = 0; k < BW + lat + 4; k++) begin
      tick(1'b1, k == 0, a, (k > lat) && (k <= BW + lat));
      if (k == 0) c0 = cyc;
    end
  endtask

  function automatic bit irr_valid(input int k);
    int vt[8] = '{3, 5, 9, 12, 14, 18, 21, 23};
    foreach (vt[i]) if (vt[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    chk("por_strobes", 32'({fsm_busy, mem_en, write_data_array, write_tag_array}), 32'h0);
    chk("por_addrs", {memory_address, data_word_addr}, 32'h0);
    tick(1'b0, 1'b1, 16'h1236, 1'b1);
    chk("por_busy_gated", 32'(fsm_busy), 32'h0);
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    mark();
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 16'h0, k[0]);
    chk("spur_writes", 32'(wr_a.size() - w0), 32'h0);
    chk("spur_busy", 32'(n_busy - b0), 32'h0);
    mark();
    fill(16'h1236, 4);
    chk("s1_issues", 32'(iss_a.size() - i0), 32'd8);
    chk("s1_first_iss", 32'(iss_a[i0]), 32'h1230);
    chk("s1_last_iss", 32'(iss_a[i0 + 7]), 32'h123E);
    chk("s1_iss_start", 32'(iss_c[i0] - c0), 32'd1);
    chk("s1_iss_span", 32'(iss_c[i0 + 7] - iss_c[i0]), 32'd7);
    chk("s1_writes", 32'(wr_a.size() - w0), 32'd8);
    chk("s1_first_wr", 32'(wr_a[w0]), 32'h1230);
    chk("s1_last_wr", 32'(wr_a[w0 + 7]), 32'h123E);
    chk("s1_tags", 32'(n_tag - t0), 32'd1);
    chk("s1_busy_cycles", 32'(n_busy - b0), 32'd13);
    mark();
    for (int k = 0; k < 27; k++) tick(1'b1, k == 0, 16'h2000, irr_valid(k));
    chk("irr_writes", 32'(wr_a.size() - w0), 32'd8);
    chk("irr_first_wr", 32'(wr_a[w0]), 32'h2000);
    chk("irr_last_wr", 32'(wr_a[w0 + 7]), 32'h200E);
    chk("irr_tags", 32'(n_tag - t0), 32'd1);
    chk("irr_busy_cycles", 32'(n_busy - b0), 32'd24);
    mark();
    for (int k = 0; k < 30; k++) begin
      tick(1'b1, k <= 13, (k >= 12) ? 16'h0080 : 16'h0040,
           ((k >= 5) && (k <= 12)) || ((k >= 18) && (k <= 25)));
      if (k == 0) c0 = cyc;
    end
    chk("b2b_issues", 32'(iss_a.size() - i0), 32'd16);
    chk("b2b_first_iss", 32'(iss_a[i0]), 32'h0040);
    chk("b2b_fill2_start", 32'(iss_c[i0 + 8] - c0), 32'd14);
    chk("b2b_fill2_base", 32'(iss_a[i0 + 8]), 32'h0080);
    chk("b2b_fill2_last", 32'(iss_a[i0 + 15]), 32'h008E);
    chk("b2b_fill2_wr", 32'(wr_a[w0 + 8]), 32'h0080);
    chk("b2b_tags", 32'(n_tag - t0), 32'd2);
    chk("b2b_busy_cycles", 32'(n_busy - b0), 32'd26);
    mark();
    fill(16'hFFF2, 4);
    chk("wrap_first_iss", 32'(iss_a[i0]), 32'hFFF0);
    chk("wrap_last_iss", 32'(iss_a[i0 + 7]), 32'hFFFE);
    chk("wrap_last_wr", 32'(wr_a[w0 + 7]), 32'hFFFE);
    chk("wrap_tags", 32'(n_tag - t0), 32'd1);
    mark();
    for (int k = 0; k < 15; k++) begin
      tick(!((k == 8) || (k == 9)), (k == 0) || (k == 9), 16'h3000, (k >= 5) && (k <= 11));
      if (k == 8) begin
        chk("rst_strobes", 32'({fsm_busy, mem_en, write_data_array, write_tag_array}), 32'h0);
        chk("rst_addrs", {memory_address, data_word_addr}, 32'h0);
      end
      if (k == 9) chk("rst_busy_gated", 32'(fsm_busy), 32'h0);
    end
    chk("rst_writes", 32'(wr_a.size() - w0), 32'd3);
    chk("rst_no_tag", 32'(n_tag - t0), 32'd0);
    mark();
    fill(16'h4000, 4);
    chk("post_rst_writes", 32'(wr_a.size() - w0), 32'd8);
    chk("post_rst_first_wr", 32'(wr_a[w0]), 32'h4000);
    chk("post_rst_tags", 32'(n_tag - t0), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 8, giving the number of 16-bit words per cache block (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 16, giving the byte-address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port miss_detected, input, 1 bit: the cache reports a miss this cycle.
REQ-006 SHALL have port miss_address, input, ADDR_W bits: the byte address that missed.
REQ-007 SHALL have port memory_data, input, 16 bits: the read data from main memory.
REQ-008 SHALL have port memory_data_valid, input, 1 bit: memory_data is valid this cycle.
REQ-009 SHALL have port fsm_busy, output, 1 bit: stall request to the pipeline.
REQ-010 SHALL have port mem_en, output, 1 bit: read request to main memory.
REQ-011 SHALL have port memory_address, output, ADDR_W bits: the read address.
REQ-012 SHALL have port write_data_array, output, 1 bit: write strobe to the cache data array.
REQ-013 SHALL have port data_word_addr, output, ADDR_W bits: the cache word address for the data write.
REQ-014 SHALL have port write_tag_array, output, 1 bit: write/validate strobe to the cache tag array.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and FILL, held in a registered state.
REQ-016 IDLE + miss_detected: SHALL latch base = miss_address with its low log2(BLOCK_WORDS)+1 bits cleared, clear both counters, and enter FILL next cycle.
REQ-017 fsm_busy SHALL be combinational: (state==FILL) | (state==IDLE & miss_detected), so the stall begins in the same cycle as the miss.
REQ-018 In FILL, the request counter req_cnt SHALL issue one read per cycle: mem_en=1 and memory_address = base + 2*req_cnt while req_cnt < BLOCK_WORDS, incrementing each cycle.
REQ-019 Once all requests have issued, mem_en SHALL be 0 and memory_address SHALL hold its last value.
REQ-020 The response counter rsp_cnt SHALL increment on each memory_data_valid in FILL.
REQ-021 write_data_array SHALL equal (state==FILL & memory_data_valid).
REQ-022 data_word_addr SHALL equal base + 2*rsp_cnt, independent of memory latency.
REQ-023 On the final response (rsp_cnt==BLOCK_WORDS-1 & memory_data_valid), write_tag_array SHALL pulse for exactly that cycle, alongside the last data write, and state SHALL return to IDLE next cycle.
REQ-024 Address arithmetic SHALL be ADDR_W-bit modulo; a block at the top of the address space SHALL wrap without error.
REQ-025 memory_data_valid in IDLE SHALL be ignored, with no writes and no counter change.
REQ-026 miss_detected during FILL SHALL be ignored; the requester SHALL hold it until fsm_busy falls.
REQ-027 A miss held across fill completion SHALL be accepted in the first IDLE cycle, so back-to-back fills have exactly one IDLE cycle between them.
REQ-028 Counters SHALL be log2(BLOCK_WORDS)+1 bits wide so the terminal count is representable without overflow.

Reset
REQ-029 Asserting rst_n low SHALL immediately force state=IDLE, req_cnt=0, rsp_cnt=0 and base=0.
REQ-030 During reset, outputs SHALL be fsm_busy=0, mem_en=0, write_data_array=0, write_tag_array=0, memory_address=0 and data_word_addr=0.
REQ-031 Reset mid-FILL SHALL abandon the fill with no tag write, and in-flight memory responses arriving after reset SHALL be ignored per REQ-025.

Structure
REQ-032 The state enumeration and the BLOCK_WORDS/ADDR_W defaults SHALL live in the shared CPU package for reuse by the I-cache and D-cache controllers.
REQ-033 SHALL instantiate one sub-module, fill_counter (an enable/clear counter with asynchronous active-low reset), twice: once for req_cnt and once for rsp_cnt.

Verification
REQ-034 Single miss: miss_address=0x1236 with a memory of fixed 4-cycle latency -> addresses 0x1230..0x123E issued on 8 consecutive cycles; 8 data writes to 0x1230..0x123E; write_tag_array pulses once with the 8th write; fsm_busy high from the miss cycle through the last write.
REQ-035 Irregular valid: responses with 1-3 idle cycles between them -> data_word_addr advances only on valid; exactly 8 writes; single tag pulse.
REQ-036 Back-to-back: miss 0x0040 with miss_detected held, then switched to 0x0080 at completion -> second fill starts after exactly one IDLE cycle; base=0x0080.
REQ-037 Wrap: miss_address=0xFFF2 -> addresses 0xFFF0..0xFFFE; no carry into unused bits.
REQ-038 Reset mid-fill: rst_n low after 3 writes -> all outputs 0 immediately; late valids produce no writes; no tag write; a new miss fills cleanly.
REQ-039 Spurious valid: memory_data_valid pulsed in IDLE -> write_data_array=0 and counters unchanged.
